control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters: none; all widths, opcodes and T-state count are fixed by this document.
REQ-002 clk  input  1  system clock; sequencer state advances on rising edge, datapath registers sample on falling edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 run  input  1  1 = sequence; 0 = freeze T-state, all control outputs 0.
REQ-005 opcode  input  4  instruction register upper nibble.
REQ-006 flag_c, flag_z  input  1 each  ALU carry / zero flags (registered externally).
REQ-007 pc_oe, pc_ie, pc_step  output  1 each  program counter drive bus / load from bus / increment.
REQ-008 mar_ie, ram_oe, ram_ie, ir_ie, ir_oe  output  1 each  memory address register, RAM and instruction register controls.
REQ-009 a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie  output  1 each  register A/B, ALU and output-register controls.
REQ-010 tstate  output  3  current microstep, 0..4.
REQ-011 halted  output  1  1 after HLT executes.

Function
REQ-012 tstate SHALL be the only sequential state besides halted; control outputs SHALL be a combinational decode of (tstate, opcode, flags) gated by run, !halted and !rst.
REQ-013 T0: pc_oe, mar_ie. T1: ram_oe, ir_ie, pc_step. Both are opcode-independent.
REQ-014 LDA(1): T2 ir_oe, mar_ie; T3 ram_oe, a_ie; end.
REQ-015 ADD(2)/SUB(3): T2 ir_oe, mar_ie; T3 ram_oe, b_ie; T4 alu_oe, a_ie, flags_ie, with alu_sub=1 for SUB only; end.
REQ-016 STA(4): T2 ir_oe, mar_ie; T3 a_oe, ram_ie; end. LDI(5): T2 ir_oe, a_ie; end.
REQ-017 JMP(6): T2 ir_oe, pc_ie; end. OUT(14): T2 a_oe, out_ie; end.
REQ-018 HLT(15): T2 asserts no control; on that rising edge halted SHALL set to 1 and tstate SHALL go to 0.
REQ-019 Undefined opcodes (9..13) SHALL act as NOP: T2 asserts no control; end.
REQ-020 "End" means tstate becomes 0 on the rising edge closing that step; no instruction SHALL visit a step beyond its last.
REQ-021 Every instruction SHALL take 3 (NOP, LDI, JMP, jumps, OUT, HLT), 4 (LDA, STA) or 5 (ADD, SUB) cycles.
REQ-022 At most one *_oe output SHALL be asserted in any cycle.
REQ-023 pc_ie and pc_step SHALL never be asserted together.
REQ-024 While halted=1, tstate SHALL hold 0 and all control outputs SHALL be 0 regardless of run; only rst clears halted.
REQ-025 run deasserted mid-instruction SHALL hold tstate; on reassertion the same step's controls SHALL resume unchanged.
REQ-026 opcode changes outside T2..T4 SHALL have no effect on outputs.

Reset
REQ-027 rst=1 SHALL immediately force tstate=0, halted=0 and all control outputs 0, independent of clk.
REQ-028 rst asserted mid-instruction SHALL abandon it; the first rising edge after release with run=1 SHALL leave T0 and enter T1.

Configuration
REQ-029 Macro CONDITIONAL_JUMP_EN: when defined, JC(7) asserts ir_oe, pc_ie at T2 only if flag_c=1, and JZ(8) likewise only if flag_z=1; both end at T2.
REQ-030 Without CONDITIONAL_JUMP_EN, opcodes 7 and 8 SHALL behave exactly as NOP (REQ-019) regardless of flags.

Verification
REQ-031 Reset, run=1, opcode=1 (LDA) -> tstate 0,1,2,3,0; T1 shows ram_oe+ir_oe... (ir_ie)+pc_step; T3 shows ram_oe+a_ie; 4 cycles.
REQ-032 opcode=3 (SUB) -> T4 asserts alu_oe, a_ie, flags_ie, alu_sub=1; tstate returns 0 after 5 cycles.
REQ-033 opcode=7, flag_c=0 then 1, macro defined -> T2 no pc_ie, then T2 pc_ie+ir_oe; macro undefined -> pc_ie never asserted.
REQ-034 opcode=15 -> halted=1 after T2; 10 further cycles with run=1 keep all outputs 0 and tstate=0; rst clears halted.
REQ-035 Drop run at T3 of ADD for 4 cycles -> tstate stays 3, outputs 0; on reassertion T3 controls reappear, T4 follows.
REQ-036 Assert rst asynchronously between edges during T2 of STA -> outputs 0 immediately, tstate=0; random-opcode run of 1000 cycles never violates REQ-022/REQ-023.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: microcode-style control unit for a small accumulator CPU.
// The only state is the T-state counter and the halted flag. All control
// outputs are a combinational decode of (tstate, opcode, flags), gated off
// while run is low, after HLT, or during reset.
// Optional feature: define CONDITIONAL_JUMP_EN to enable JC(7) and JZ(8).
// Without it, opcodes 7 and 8 decode as NOP.
//
// state | meaning
// ------+------------------------------------------------
// T0    | fetch: PC onto bus, load MAR
// T1    | fetch: RAM into IR, increment PC
// T2    | execute step 1 (operand address / immediate / jump)
// T3    | execute step 2 (LDA, ADD, SUB, STA only)
// T4    | execute step 3 (ADD, SUB only)

module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic       pc_oe,
    output logic       pc_ie,
    output logic       pc_step,
    output logic       mar_ie,
    output logic       ram_oe,
    output logic       ram_ie,
    output logic       ir_ie,
    output logic       ir_oe,
    output logic       a_ie,
    output logic       a_oe,
    output logic       b_ie,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       flags_ie,
    output logic       out_ie,
    output logic [2:0] tstate,
    output logic       halted
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_STA = 4'd4;
    localparam logic [3:0] OP_LDI = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JC  = 4'd7;
    localparam logic [3:0] OP_JZ  = 4'd8;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    tstate_t state;
    tstate_t last_step;
    logic    active;

    assign tstate = state;
    assign active = run && !halted && !rst;

`ifndef CONDITIONAL_JUMP_EN
    // Flags only steer conditional jumps; keep them referenced when those are compiled out.
    logic flags_unused;
    assign flags_unused = flag_c ^ flag_z;
`endif

    // Final microstep of the current instruction; anything else ends at T2.
    always_comb begin
        last_step = T2;
        case (opcode)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    // T-state advance and halt latch; >= guards against an opcode that changes mid-instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T0;
            halted <= 1'b0;
        end else if (halted) begin
            state <= T0;
        end else if (run) begin
            if (state == T2 && opcode == OP_HLT) begin
                halted <= 1'b1;
                state  <= T0;
            end else if (state >= last_step) begin
                state <= T0;
            end else begin
                state <= tstate_t'(state + 3'd1);
            end
        end
    end

    // Control word decode for the current microstep.
    always_comb begin
        pc_oe    = 1'b0;
        pc_ie    = 1'b0;
        pc_step  = 1'b0;
        mar_ie   = 1'b0;
        ram_oe   = 1'b0;
        ram_ie   = 1'b0;
        ir_ie    = 1'b0;
        ir_oe    = 1'b0;
        a_ie     = 1'b0;
        a_oe     = 1'b0;
        b_ie     = 1'b0;
        alu_oe   = 1'b0;
        alu_sub  = 1'b0;
        flags_ie = 1'b0;
        out_ie   = 1'b0;
        if (active) begin
            case (state)
                T0: begin
                    pc_oe  = 1'b1;
                    mar_ie = 1'b1;
                end
                T1: begin
                    ram_oe  = 1'b1;
                    ir_ie   = 1'b1;
                    pc_step = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_oe  = 1'b1;
                            mar_ie = 1'b1;
                        end
                        OP_LDI: begin
                            ir_oe = 1'b1;
                            a_ie  = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe = 1'b1;
                            pc_ie = 1'b1;
                        end
`ifdef CONDITIONAL_JUMP_EN
                        OP_JC: begin
                            ir_oe = flag_c;
                            pc_ie = flag_c;
                        end
                        OP_JZ: begin
                            ir_oe = flag_z;
                            pc_ie = flag_z;
                        end
`endif
                        OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ie = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_ie   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_ie   = 1'b1;
                        end
                        OP_STA: begin
                            a_oe   = 1'b1;
                            ram_ie = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe   = 1'b1;
                        a_ie     = 1'b1;
                        flags_ie = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer. Each scenario pushes per-cycle stimulus and
// the expected {tstate, halted, control word} onto a scoreboard queue, then
// drains it one clock at a time, comparing against the DUT between edges.
// Honours CONDITIONAL_JUMP_EN the same way as the design.

module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [3:0] opcode;
    logic       flag_c;
    logic       flag_z;
    logic       pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
    logic       a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie;
    logic [2:0] tstate;
    logic       halted;

    control_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .flag_c(flag_c), .flag_z(flag_z),
        .pc_oe(pc_oe), .pc_ie(pc_ie), .pc_step(pc_step), .mar_ie(mar_ie),
        .ram_oe(ram_oe), .ram_ie(ram_ie), .ir_ie(ir_ie), .ir_oe(ir_oe),
        .a_ie(a_ie), .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe),
        .alu_sub(alu_sub), .flags_ie(flags_ie), .out_ie(out_ie),
        .tstate(tstate), .halted(halted)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] C_PC_OE    = 15'h4000;
    localparam logic [14:0] C_PC_IE    = 15'h2000;
    localparam logic [14:0] C_PC_STEP  = 15'h1000;
    localparam logic [14:0] C_MAR_IE   = 15'h0800;
    localparam logic [14:0] C_RAM_OE   = 15'h0400;
    localparam logic [14:0] C_RAM_IE   = 15'h0200;
    localparam logic [14:0] C_IR_IE    = 15'h0100;
    localparam logic [14:0] C_IR_OE    = 15'h0080;
    localparam logic [14:0] C_A_IE     = 15'h0040;
    localparam logic [14:0] C_A_OE     = 15'h0020;
    localparam logic [14:0] C_B_IE     = 15'h0010;
    localparam logic [14:0] C_ALU_OE   = 15'h0008;
    localparam logic [14:0] C_ALU_SUB  = 15'h0004;
    localparam logic [14:0] C_FLAGS_IE = 15'h0002;
    localparam logic [14:0] C_OUT_IE   = 15'h0001;

    wire [14:0] ctl = {pc_oe, pc_ie, pc_step, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe,
                       a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie};
    wire [18:0] obs = {tstate, halted, ctl};

    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        logic [18:0] exp;
    } ent_t;

    ent_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input logic r, input logic [3:0] op, input logic fc, input logic fz,
                        input logic [2:0] ts, input logic h, input logic [14:0] c);
        ent_t e;
        e.r   = r;
        e.op  = op;
        e.fc  = fc;
        e.fz  = fz;
        e.exp = {ts, h, c};
        sb.push_back(e);
    endtask

    // Queue one whole instruction; opcode is randomised during fetch (must not matter).
    // hold_step >= 0 inserts four run=0 cycles in front of that step.
    task automatic push_instr(input logic [3:0] op, input logic fc, input logic fz,
                              input int hold_step);
        logic [14:0] c [5];
        int n;
        c[0] = C_PC_OE | C_MAR_IE;
        c[1] = C_RAM_OE | C_IR_IE | C_PC_STEP;
        c[2] = '0;
        c[3] = '0;
        c[4] = '0;
        n = 3;
        case (op)
            4'd1: begin c[2] = C_IR_OE | C_MAR_IE; c[3] = C_RAM_OE | C_A_IE; n = 4; end
            4'd2: begin
                c[2] = C_IR_OE | C_MAR_IE; c[3] = C_RAM_OE | C_B_IE;
                c[4] = C_ALU_OE | C_A_IE | C_FLAGS_IE; n = 5;
            end
            4'd3: begin
                c[2] = C_IR_OE | C_MAR_IE; c[3] = C_RAM_OE | C_B_IE;
                c[4] = C_ALU_OE | C_A_IE | C_FLAGS_IE | C_ALU_SUB; n = 5;
            end
            4'd4:  begin c[2] = C_IR_OE | C_MAR_IE; c[3] = C_A_OE | C_RAM_IE; n = 4; end
            4'd5:  c[2] = C_IR_OE | C_A_IE;
            4'd6:  c[2] = C_IR_OE | C_PC_IE;
`ifdef CONDITIONAL_JUMP_EN
            4'd7:  if (fc) c[2] = C_IR_OE | C_PC_IE;
            4'd8:  if (fz) c[2] = C_IR_OE | C_PC_IE;
`endif
            4'd14: c[2] = C_A_OE | C_OUT_IE;
            default: ;
        endcase
        for (int i = 0; i < n; i++) begin
            if (i == hold_step)
                for (int k = 0; k < 4; k++) push(1'b0, op, fc, fz, 3'(i), 1'b0, 15'd0);
            push(1'b1, (i < 2) ? 4'($urandom_range(0, 15)) : op, fc, fz, 3'(i), 1'b0, c[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b1; opcode = 4'd1; flag_c = 1'b0; flag_z = 1'b0;
        #1;
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_immediate: got %b want %b", obs, 19'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_held: got %b want %b", obs, 19'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lda();
        ent_t e;
        push_instr(4'd1, 1'b0, 1'b0, -1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL lda: got %b want %b", obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sub();
        ent_t e;
        push_instr(4'd3, 1'b1, 1'b1, -1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL sub: got %b want %b", obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cond_jump();
        ent_t e;
        push_instr(4'd7, 1'b0, 1'b1, -1);
        push_instr(4'd7, 1'b1, 1'b0, -1);
        push_instr(4'd8, 1'b1, 1'b0, -1);
        push_instr(4'd8, 1'b0, 1'b1, -1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL cond_jump op%0d c%0b z%0b: got %b want %b",
                         e.op, e.fc, e.fz, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        logic [3:0] ops [12];
        ops = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd14, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd7, 4'd8};
        foreach (ops[i])
            push_instr(ops[i], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL back_to_back op%0d: got %b want %b", e.op, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_freeze();
        ent_t e;
        push_instr(4'd2, 1'b0, 1'b0, 3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL run_freeze run=%0b: got %b want %b", e.r, obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        ent_t e;
        push_instr(4'd15, 1'b0, 1'b0, -1);
        for (int i = 0; i < 10; i++)
            push(1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b1, 3'd0, 1'b1, 15'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL halt: got %b want %b", obs, e.exp);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_clear: halted got %b want 0", halted);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_async_reset();
        ent_t e;
        push(1'b1, 4'd4, 1'b0, 1'b0, 3'd0, 1'b0, C_PC_OE | C_MAR_IE);
        push(1'b1, 4'd4, 1'b0, 1'b0, 3'd1, 1'b0, C_RAM_OE | C_IR_IE | C_PC_STEP);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL async_reset_fetch: got %b want %b", obs, e.exp);
            end
            @(negedge clk);
        end
        run = 1'b1; opcode = 4'd4;
        #1;
        vectors++;
        if (obs !== {3'd2, 1'b0, C_IR_OE | C_MAR_IE}) begin
            miscompares++;
            $display("FAIL sta_t2: got %b want %b", obs, {3'd2, 1'b0, C_IR_OE | C_MAR_IE});
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 19'd0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %b want %b", obs, 19'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        push_instr(4'd4, 1'b0, 1'b0, -1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            run = e.r; opcode = e.op; flag_c = e.fc; flag_z = e.fz;
            #1;
            vectors++;
            if (obs !== e.exp) begin
                miscompares++;
                $display("FAIL after_reset: got %b want %b", obs, e.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_invariants();
        int oe_cnt;
        for (int i = 0; i < 1000; i++) begin
            run    = ($urandom_range(0, 9) != 0);
            opcode = 4'($urandom_range(0, 14));
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            #1;
            oe_cnt = int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe);
            vectors++;
            if (oe_cnt > 1 || (pc_ie && pc_step) || tstate > 3'd4 || halted) begin
                miscompares++;
                $display("FAIL invariant cycle %0d: oe_count %0d pc_ie %b pc_step %b tstate %0d halted %b (want oe<=1, not both, tstate<=4, halted 0)",
                         i, oe_cnt, pc_ie, pc_step, tstate, halted);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sub();
        test_cond_jump();
        test_back_to_back();
        test_run_freeze();
        test_halt();
        test_async_reset();
        test_random_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
